reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2: number of read ports.
REQ-004 Parameter NUM_WR, default 2: number of write ports; legal values 1..4.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  NUM_WR  per-port write enable.
REQ-008 wr_addr  input  NUM_WR*ADDR_W  flattened write addresses; port k occupies slice k.
REQ-009 wr_data  input  NUM_WR*DATA_W  flattened write data.
REQ-010 rd_en  input  NUM_RD  per-port read request.
REQ-011 rd_addr  input  NUM_RD*ADDR_W  flattened read addresses.
REQ-012 rd_data  output  NUM_RD*DATA_W  flattened registered read data.
REQ-013 rd_valid  output  NUM_RD  per-port read-data-valid pulse.
REQ-014 ready  output  1  high when initialisation is complete and ports are accepted.
REQ-015 wr_conflict  output  1  one-cycle pulse on same-address multi-port write.

Function
REQ-016 Storage SHALL be 2**ADDR_W x DATA_W; entry 0 SHALL always read 0, and writes to address 0 SHALL be discarded.
REQ-017 FSM SHALL have two states: INIT (sweep), READY; INIT -> READY after the last entry is cleared; READY -> INIT only on reset.
REQ-018 In INIT, one entry per cycle SHALL be written to 0 at init_ptr, starting at 0 and incrementing; ready SHALL rise the cycle after entry 2**ADDR_W-1 is cleared (2**ADDR_W cycles after reset release).
REQ-019 In INIT, wr_en and rd_en SHALL be ignored; rd_valid SHALL stay 0 and rd_data SHALL hold.
REQ-020 In READY, port k SHALL write wr_data slice k to wr_addr slice k on the rising edge when wr_en[k]=1 and the address is nonzero.
REQ-021 When two or more enabled write ports target the same nonzero address in one cycle, the highest-index port SHALL win and wr_conflict SHALL be 1 in the following cycle only.
REQ-022 Reads SHALL have one-cycle latency: rd_addr sampled on edge N with rd_en[j]=1 gives rd_data slice j and rd_valid[j]=1 after edge N+1's setup, i.e. during cycle N+1.
REQ-023 rd_valid[j] SHALL be 0 in any cycle following an edge with rd_en[j]=0; rd_data slice j SHALL hold its last value.
REQ-024 Read of an address written on the same edge SHALL return the pre-write value unless the bypass feature is compiled in.
REQ-025 Multiple read ports SHALL be independent; identical addresses on different ports SHALL return identical data.

Reset
REQ-026 reset=0 on a rising edge SHALL force state INIT, init_ptr=0, ready=0, rd_valid=0, rd_data=0, wr_conflict=0 from the next cycle.
REQ-027 Reset asserted mid-sweep or mid-operation SHALL restart the sweep at entry 0 and drop any same-cycle writes and reads.
REQ-028 Storage contents SHALL not be relied upon until ready=1; after ready=1 every entry SHALL read 0 until written.

Configuration
REQ-029 Macro RF_BYPASS_EN defined: a same-edge read of an address being written SHALL return the winning port's wr_data (write-first); address 0 still returns 0.
REQ-030 Macro RF_BYPASS_EN undefined: same-edge read SHALL return the old stored value (read-first); no bypass muxes SHALL be built.

Verification
REQ-031 Reset low 1 cycle, release -> ready=0 for 32 cycles, ready=1 on cycle 32; all 32 addresses then read 0x00000000.
REQ-032 Write port 0 addr 5 data 0xDEADBEEF, next cycle read port 1 addr 5 -> rd_data1=0xDEADBEEF, rd_valid[1]=1 exactly one cycle.
REQ-033 Write addr 0 data 0xFFFFFFFF, then read addr 0 -> rd_data=0x00000000.
REQ-034 Ports 0 and 1 both write addr 7 (0x11111111, 0x22222222) same edge -> addr 7 reads 0x22222222; wr_conflict pulses one cycle.
REQ-035 Addr 9 holds 0xA; same edge write 0xB and read addr 9 -> rd_data=0xB with RF_BYPASS_EN, 0xA without.
REQ-036 Assert reset at sweep entry 10, release -> sweep restarts at 0; ready rises 32 cycles after release; rd_en pulses during sweep give rd_valid=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file, DEPTH = 2**ADDR_W entries of DATA_W bits.
// Entry 0 is hard-wired to zero. After reset release, an INIT sweep clears one
// entry per cycle, and ready rises once every entry has been cleared.
// Reads are registered (one-cycle latency). When several ports write the same
// address on one edge, the highest-index port wins and wr_conflict pulses.
// Optional macro RF_BYPASS_EN: a read of an address written on the same edge
// returns the new data (write-first). Without it the read returns the old value.
// NUM_WR is intended to be 1..4.
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic                       ready,
  output logic                       wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   rd_data_q [NUM_RD];
  logic [DATA_W-1:0]   rd_data_d [NUM_RD];
  logic [NUM_RD-1:0]   rd_valid_q, rd_valid_d;
  logic                wr_conflict_q, wr_conflict_d;
  logic                accept;

  logic [ADDR_W-1:0]   wr_addr_a [NUM_WR];
  logic [DATA_W-1:0]   wr_data_a [NUM_WR];
  logic [ADDR_W-1:0]   rd_addr_a [NUM_RD];

  // Unpack the flattened port buses into per-port arrays.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
    assign wr_addr_a[gi] = wr_addr[gi*ADDR_W +: ADDR_W];
    assign wr_data_a[gi] = wr_data[gi*DATA_W +: DATA_W];
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_unpack
    assign rd_addr_a[gi]                 = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_data[gi*DATA_W +: DATA_W]  = rd_data_q[gi];
  end

  // Ports are only honoured once the clearing sweep has finished.
  assign accept      = (state_q == ST_READY);
  assign ready       = accept;
  assign rd_valid    = rd_valid_q;
  assign wr_conflict = wr_conflict_q;

  // Next-state logic: sweep init_ptr through every entry, then go to READY.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (&init_ptr_q) begin
        state_d = ST_READY;
      end
    end
  end

  // Storage update: clear one entry during the sweep; otherwise apply the
  // writes in port order so the highest-index port lands last and wins.
  always_comb begin
    mem_d = mem_q;
    if (!accept) begin
      mem_d[init_ptr_q] = '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr_a[k] != '0)) begin
          mem_d[wr_addr_a[k]] = wr_data_a[k];
        end
      end
    end
  end

  // Conflict detect: any pair of enabled ports writing the same nonzero address.
  always_comb begin
    wr_conflict_d = 1'b0;
    if (accept) begin
      for (int i = 0; i < NUM_WR; i++) begin
        for (int k = i + 1; k < NUM_WR; k++) begin
          if (wr_en[i] && wr_en[k] && (wr_addr_a[i] == wr_addr_a[k]) &&
              (wr_addr_a[i] != '0)) begin
            wr_conflict_d = 1'b1;
          end
        end
      end
    end
  end

  // Read path: capture the addressed entry when requested; otherwise hold data.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    if (accept) begin
      for (int j = 0; j < NUM_RD; j++) begin
        if (rd_en[j]) begin
          rd_valid_d[j] = 1'b1;
          rd_data_d[j]  = (rd_addr_a[j] == '0) ? '0 : mem_q[rd_addr_a[j]];
`ifdef RF_BYPASS_EN
          for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr_a[k] == rd_addr_a[j]) && (rd_addr_a[j] != '0)) begin
              rd_data_d[j] = wr_data_a[k];
            end
          end
`endif
        end
      end
    end
  end

  // Storage array: updates are dropped while reset is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= mem_d;
    end
  end

  // Control and read-port registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= '0;
      rd_valid_q    <= '0;
      rd_data_q     <= '{default: '0};
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

endmodule
